// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the load/store data port and the external memory
//   handshake seen by mem_port_arbiter.
//   Modports:
//     slave  - the arbiter's view: takes requests and memory responses,
//              drives ready/rdata pulses and the memory request.
//     master - the surrounding system's view (cpu core + memory model).
//   Signals:
//     if_req/if_addr/if_rdata/if_ready          instruction fetch port
//     d_req/d_we/d_addr/d_wdata/d_rdata/d_ready load/store port
//     m_req/m_we/m_addr/m_wdata/m_rdata/m_ack   memory handshake
//     err                                       timed-out access flag
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the CPU instruction-fetch
//   path and the load/store data path. One access is in flight at a time;
//   the winner gets a one-cycle ready pulse carrying registered read data.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high
//     bus    - mem_port_arbiter_if.slave (fetch, data and memory handshakes)
//   Parameters:
//     TIMEOUT_CYCLES - max cycles m_req may stay high without m_ack
//                      (0 disables the timeout)
//   Configuration macro:
//     MEM_ARB_RR_EN  - when defined, simultaneous requests are served
//                      round-robin; otherwise data beats fetch.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

  logic elig_if;
  logic elig_d;
  logic grant_if;
  logic grant_d;
  logic timeout_hit;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  grant_t last_grant;
`endif

  // A requester whose ready pulse is out this cycle is still holding req
  // for the access that just finished, so it is masked for one cycle.
  always_comb begin
    elig_if = bus.if_req && !bus.if_ready;
    elig_d  = bus.d_req  && !bus.d_ready;
`ifdef MEM_ARB_RR_EN
    if (elig_if && elig_d) begin
      grant_d  = (last_grant == GRANT_IF);
      grant_if = !grant_d;
    end else begin
      grant_d  = elig_d;
      grant_if = elig_if;
    end
`else
    grant_d  = elig_d;
    grant_if = elig_if && !elig_d;
`endif
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      assign timeout_hit = (tmo_cnt == TMO_LAST);
    end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      bus.err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant   <= GRANT_IF;
`endif
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      bus.err      <= 1'b0;

      case (state)
        IDLE: begin
          // m_ack seen here is late or spurious and is ignored.
          if (grant_d) begin
            state       <= BUSY_D;
            tmo_cnt     <= '0;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
`ifdef MEM_ARB_RR_EN
            last_grant  <= GRANT_D;
`endif
          end else if (grant_if) begin
            state       <= BUSY_IF;
            tmo_cnt     <= '0;
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= bus.if_addr;
            bus.m_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= GRANT_IF;
`endif
          end
        end

        BUSY_IF: begin
          // An ack in the timeout cycle completes normally.
          if (bus.m_ack) begin
            state        <= IDLE;
            bus.m_req    <= 1'b0;
            bus.if_rdata <= bus.m_rdata;
            bus.if_ready <= 1'b1;
          end else if (timeout_hit) begin
            state        <= IDLE;
            bus.m_req    <= 1'b0;
            bus.if_rdata <= '0;
            bus.if_ready <= 1'b1;
            bus.err      <= 1'b1;
          end else begin
            tmo_cnt      <= tmo_cnt + 1'b1;
          end
        end

        BUSY_D: begin
          if (bus.m_ack) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.d_rdata <= bus.m_rdata;
            bus.d_ready <= 1'b1;
          end else if (timeout_hit) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_ready <= 1'b1;
            bus.err     <= 1'b1;
          end else begin
            tmo_cnt     <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          bus.m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  bit          last_was_d;     // who the arbiter served last
  logic [31:0] held_if_rdata;
  logic [31:0] held_d_rdata;
  bit          d_rdata_known;  // false after a completed store

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles m_req stays high for an access acked in busy cycle j.
  function automatic int unsigned dur(input int unsigned j);
    return (j <= T - 1) ? j + 1 : T;
  endfunction

  function automatic bit tie_d_wins();
`ifdef MEM_ARB_RR_EN
    return !last_was_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    last_was_d    = 1'b0;
    held_if_rdata = '0;
    held_d_rdata  = '0;
    d_rdata_known = 1'b1;
  endtask

  // Issues one or two requests at once and acts as the memory. j_a/rd_a
  // belong to the first access granted, j_b/rd_b to the second.
  task automatic run_case(input string name, input bit use_if, input bit use_d,
                          input bit we, input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] wd, input int unsigned j_a,
                          input int unsigned j_b, input logic [31:0] rd_a,
                          input logic [31:0] rd_b);
    bit          s_d [2];
    int unsigned s_j [2];
    logic [31:0] s_rd [2];
    int unsigned g [2];
    int unsigned r [2];
    int unsigned n, gi, ri, cur, b, mreq_hi, exp_hi;
    bit          mreq_prev, tmo, d_first;
    logic [31:0] exp_rd, got_rd;

    n = 0;
    d_first = (use_if && use_d) ? tie_d_wins() : use_d;
    if (use_d && d_first)  begin s_d[n] = 1'b1; n++; end
    if (use_if)            begin s_d[n] = 1'b0; n++; end
    if (use_d && !d_first) begin s_d[n] = 1'b1; n++; end
    s_j[0] = j_a;  s_rd[0] = rd_a;
    s_j[1] = j_b;  s_rd[1] = rd_b;
    g[0] = 1;
    r[0] = g[0] + dur(s_j[0]);
    g[1] = r[0] + 1;
    r[1] = g[1] + dur(s_j[1]);
    exp_hi = dur(s_j[0]) + ((n > 1) ? dur(s_j[1]) : 0);
    if (n > 0) last_was_d = s_d[n-1];

    bus.if_req  = use_if;
    bus.if_addr = ia;
    bus.d_req   = use_d;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.m_ack   = 1'b0;
    gi = 0; ri = 0; cur = 0; b = 0; mreq_hi = 0; mreq_prev = 1'b0;

    for (int unsigned cyc = 1; cyc <= r[n-1] + 2; cyc++) begin
      step();
      if (bus.m_req && !mreq_prev) begin
        vectors++;
        if (gi >= n) begin
          miscompares++;
          $display("FAIL %s extra_grant: cycle %0d, none expected", name, cyc);
        end else begin
          if (cyc !== g[gi] || bus.m_addr !== (s_d[gi] ? da : ia) ||
              bus.m_we !== (s_d[gi] ? we : 1'b0) ||
              bus.m_wdata !== (s_d[gi] ? wd : 32'h0)) begin
            miscompares++;
            $display("FAIL %s grant%0d: cyc=%0d addr=%h we=%b wdata=%h, want cyc=%0d addr=%h we=%b wdata=%h",
                     name, gi, cyc, bus.m_addr, bus.m_we, bus.m_wdata, g[gi],
                     s_d[gi] ? da : ia, s_d[gi] ? we : 1'b0, s_d[gi] ? wd : 32'h0);
          end
          cur = gi; gi++; b = 0;
        end
      end
      if (bus.m_req) mreq_hi++;

      if (bus.if_ready || bus.d_ready) begin
        vectors++;
        if (ri >= n) begin
          miscompares++;
          $display("FAIL %s extra_ready: cycle %0d if_ready=%b d_ready=%b", name, cyc, bus.if_ready, bus.d_ready);
        end else begin
          tmo    = (s_j[ri] > T - 1);
          exp_rd = tmo ? 32'h0 : s_rd[ri];
          got_rd = s_d[ri] ? bus.d_rdata : bus.if_rdata;
          if (bus.d_ready !== s_d[ri] || bus.if_ready !== !s_d[ri] ||
              cyc !== r[ri] || bus.err !== tmo ||
              (!(s_d[ri] && we && !tmo) && got_rd !== exp_rd)) begin
            miscompares++;
            $display("FAIL %s ready%0d: cyc=%0d d_ready=%b if_ready=%b err=%b rdata=%h, want cyc=%0d d=%b err=%b rdata=%h",
                     name, ri, cyc, bus.d_ready, bus.if_ready, bus.err, got_rd,
                     r[ri], s_d[ri], tmo, exp_rd);
          end
          vectors++;
          if (s_d[ri] ? (bus.if_rdata !== held_if_rdata)
                      : (d_rdata_known && bus.d_rdata !== held_d_rdata)) begin
            miscompares++;
            $display("FAIL %s hold%0d: other rdata if=%h d=%h, want if=%h d=%h",
                     name, ri, bus.if_rdata, bus.d_rdata, held_if_rdata, held_d_rdata);
          end
          if (s_d[ri]) begin
            held_d_rdata  = exp_rd;
            d_rdata_known = !(we && !tmo);
            bus.d_req     = 1'b0;
          end else begin
            held_if_rdata = exp_rd;
            bus.if_req    = 1'b0;
          end
          ri++;
        end
      end

      bus.m_ack = 1'b0;
      if (bus.m_req) begin
        if (b == s_j[cur]) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = s_rd[cur];
        end else begin
          bus.m_rdata = $urandom();
        end
        b++;
      end
      mreq_prev = bus.m_req;
    end

    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.m_ack  = 1'b0;
    vectors++;
    if (gi !== n || ri !== n || mreq_hi !== exp_hi) begin
      miscompares++;
      $display("FAIL %s totals: grants=%0d readies=%0d m_req_cycles=%0d, want %0d %0d %0d",
               name, gi, ri, mreq_hi, n, n, exp_hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    step(); step();
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: m_req,m_we,if_ready,d_ready,err=%b want 00000",
               {bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.err});
    end
    vectors++;
    if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 ||
        bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: m_addr=%h m_wdata=%h if_rdata=%h d_rdata=%h want all 0",
               bus.m_addr, bus.m_wdata, bus.if_rdata, bus.d_rdata);
    end
  endtask

  task automatic test_single_fetch();
    run_case("single_fetch", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0,
             2, 0, 32'hE3A01005, 32'h0);
    step();
  endtask

  task automatic test_store();
    run_case("store", 1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hCAFEF00D,
             0, 0, 32'h5555AAAA, 32'h0);
    step();
    run_case("load", 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0,
             1, 0, 32'h0BADBEEF, 32'h0);
    step();
  endtask

  task automatic test_tie();
    run_case("tie", 1'b1, 1'b1, 1'b0, 32'h200, 32'h80, 32'h0,
             1, 1, 32'h11112222, 32'h33334444);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rq[$];
    bit          exp_d;
    int unsigned seen;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h90;
    exp_d = tie_d_wins();
    seen  = 0;
    for (int unsigned cyc = 0; cyc < 40 && seen < 6; cyc++) begin
      step();
      if (bus.if_ready || bus.d_ready) begin
        vectors++;
        if (bus.d_ready !== exp_d || bus.if_ready !== !exp_d || rq.size() == 0 ||
            (exp_d ? bus.d_rdata : bus.if_rdata) !== rq[0]) begin
          miscompares++;
          $display("FAIL back_to_back%0d: d_ready=%b if_ready=%b rdata=%h, want d=%b rdata=%h",
                   seen, bus.d_ready, bus.if_ready, exp_d ? bus.d_rdata : bus.if_rdata,
                   exp_d, (rq.size() > 0) ? rq[0] : 32'h0);
        end
        if (rq.size() > 0) void'(rq.pop_front());
        last_was_d = exp_d;
        if (exp_d) held_d_rdata = bus.d_rdata; else held_if_rdata = bus.if_rdata;
        d_rdata_known = 1'b1;
        exp_d = !exp_d;
        seen++;
      end
      bus.m_ack = 1'b0;
      if (bus.m_req) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = $urandom();
        rq.push_back(bus.m_rdata);
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_ack = 1'b0;
    vectors++;
    if (seen !== 6) begin
      miscompares++;
      $display("FAIL back_to_back_count: readies=%0d want 6", seen);
    end
    step(); step();
  endtask

  task automatic test_timeout();
    run_case("timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'h60, 32'h0,
             99, 0, 32'h0, 32'h0);
    bus.m_ack = 1'b1; bus.m_rdata = 32'hFEEDFACE;
    step();
    bus.m_ack = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({bus.m_req, bus.if_ready, bus.d_ready, bus.err} !== 4'b0 || bus.d_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL late_ack%0d: m_req,if_ready,d_ready,err=%b d_rdata=%h want 0000 0",
                 k, {bus.m_req, bus.if_ready, bus.d_ready, bus.err}, bus.d_rdata);
      end
    end
    run_case("ack_on_timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'h64, 32'h0,
             T - 1, 0, 32'h12345678, 32'h0);
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'hA0; bus.d_wdata = 32'h77;
    got = 1'b0;
    for (int unsigned k = 0; k < 5 && !got; k++) begin
      step();
      got = bus.m_req;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL reset_mid_grant: m_req=0 want 1 within 5 cycles");
    end
    step();
    reset = 1'b1; bus.d_req = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.err} !== 5'b0 ||
        bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 ||
        bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: ctrl=%b m_addr=%h m_wdata=%h want all 0",
               {bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.err}, bus.m_addr, bus.m_wdata);
    end
    bus.m_ack = 1'b1; bus.m_rdata = 32'hDEADDEAD;
    step();
    bus.m_ack = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({bus.m_req, bus.if_ready, bus.d_ready, bus.err} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_mid_ack%0d: m_req,if_ready,d_ready,err=%b want 0000",
                 k, {bus.m_req, bus.if_ready, bus.d_ready, bus.err});
      end
    end
    run_case("after_reset_fetch", 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0,
             1, 0, 32'hE1A00000, 32'h0);
    step();
  endtask

  task automatic test_random();
    int unsigned mode;
    for (int unsigned it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      run_case("random", mode != 1, mode != 0, 1'($urandom_range(0, 1)),
               $urandom(), $urandom(), $urandom(),
               $urandom_range(0, T + 1), $urandom_range(0, T + 1),
               $urandom(), $urandom());
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
